fp_accum_sat: RTL

FP_ACCUM_SAT -- requirements
Module: fp_accum_sat

---
 rtl/fp_accum_sat.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fp_accum_sat.sv
// -----------------------------------------------------------------------------
// fp_accum_sat
//   Block accumulator for signed fixed-point samples. Sums N_ACC valid samples
//   of format S(NB_IN,NBF_IN) into a guard-bit-extended accumulator, then emits
//   the block sum truncated (floor) to S(NB_OUT,NBF_OUT) and saturated to the
//   output range, together with a one-cycle o_valid pulse.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   i_rst    : synchronous active-high reset, highest priority
//   i_clear  : synchronous flush of the partial block (beats i_valid)
//   i_valid  : qualifies i_data
//   i_data   : signed sample, S(NB_IN,NBF_IN)
//   o_valid  : one-cycle pulse, o_data/o_sat describe a new block
//   o_data   : truncated and saturated block sum, S(NB_OUT,NBF_OUT)
//   o_sat    : saturation was applied to o_data
//   o_busy   : a partial block is held (state ACCUM)
// -----------------------------------------------------------------------------
module fp_accum_sat #(
  parameter int NB_IN   = 17,
  parameter int NBF_IN  = 14,
  parameter int NB_OUT  = 11,
  parameter int NBF_OUT = 10,
  parameter int N_ACC   = 4
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic signed [NB_IN-1:0]  i_data,
  output logic                     o_valid,
  output logic signed [NB_OUT-1:0] o_data,
  output logic                     o_sat,
  output logic                     o_busy
);

  // Accumulator is wide enough that N_ACC full-scale samples cannot overflow.
  localparam int NB_ACC = NB_IN + $clog2(N_ACC) + 1;
  localparam int CNT_W  = (N_ACC > 1) ? $clog2(N_ACC) : 1;
  localparam int SHIFT  = NBF_IN - NBF_OUT;       // fractional LSBs dropped
  localparam int NB_TR  = NB_ACC - SHIFT;         // width after truncation
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ACC - 1);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [NB_ACC-1:0]   acc_q, acc_d;
  logic                       o_valid_q, o_valid_d;
  logic signed [NB_OUT-1:0]   o_data_q, o_data_d;
  logic                       o_sat_q, o_sat_d;

  logic signed [NB_ACC-1:0]   data_ext;
  logic signed [NB_ACC-1:0]   sum;
  logic signed [NB_TR-1:0]    sum_tr;
  logic [NB_TR-NB_OUT:0]      ovf_bits;
  logic                       in_range;
  logic signed [NB_OUT-1:0]   sat_data;
  logic                       last_sample;

  // acc_q is zero whenever the FSM is in IDLE (reset, clear and block
  // completion all zero it), so acc_q + sample also serves as the first sum.
  assign data_ext    = {{(NB_ACC-NB_IN){i_data[NB_IN-1]}}, i_data};
  assign sum         = acc_q + data_ext;

  // Arithmetic right shift by slicing off the LSBs: floor toward -inf.
  assign sum_tr      = sum[NB_ACC-1:SHIFT];

  // The value fits the output only if the discarded MSBs and the output sign
  // bit are all copies of one another.
  assign ovf_bits    = sum_tr[NB_TR-1:NB_OUT-1];
  assign in_range    = (&ovf_bits) | ~(|ovf_bits);
  assign sat_data    = sum[NB_ACC-1] ? {1'b1, {(NB_OUT-1){1'b0}}}
                                     : {1'b0, {(NB_OUT-1){1'b1}}};
  // With N_ACC = 1, CNT_LAST is 0, so the first sample in IDLE completes.
  assign last_sample = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    o_valid_d = 1'b0;
    o_data_d  = o_data_q;
    o_sat_d   = o_sat_q;

    if (i_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (i_valid) begin
      if (last_sample) begin
        state_d   = IDLE;
        cnt_d     = '0;
        acc_d     = '0;
        o_valid_d = 1'b1;
        o_data_d  = in_range ? sum_tr[NB_OUT-1:0] : sat_data;
        o_sat_d   = ~in_range;
      end else begin
        state_d = ACCUM;
        cnt_d   = cnt_q + CNT_W'(1);
        acc_d   = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_sat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_sat_q   <= o_sat_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_sat   = o_sat_q;
  assign o_busy  = (state_q == ACCUM);

endmodule
